// File: rtl/cpu_pipe_pkg.sv
// ---------------------------------------------------------------------------
// cpu_pipe_pkg
//   Shared constants and helpers for the CPU pipeline registers.
//   - NOP_INSTR : bubble encoding for instruction-carrying stages
//   - PC_RESET  : program counter value after reset
//   - CNT_W     : width of the optional stall/flush performance counters
//   - stage_op_e / decode_op : resolves clr > flush > stall > load priority
//     once, so every stage cell applies the same rule.
// ---------------------------------------------------------------------------
package cpu_pipe_pkg;

  localparam logic [31:0] NOP_INSTR = 32'h0000_0000;
  localparam logic [31:0] PC_RESET  = 32'h0000_0000;
  localparam int          CNT_W     = 32;

  typedef enum logic [1:0] {
    OP_CLR   = 2'd0,
    OP_FLUSH = 2'd1,
    OP_HOLD  = 2'd2,
    OP_LOAD  = 2'd3
  } stage_op_e;

  function automatic stage_op_e decode_op(input logic clr,
                                          input logic flush,
                                          input logic stall);
    if (clr)   return OP_CLR;
    if (flush) return OP_FLUSH;
    if (stall) return OP_HOLD;
    return OP_LOAD;
  endfunction

endpackage

// File: rtl/pipe_stage_cell.sv
// ---------------------------------------------------------------------------
// pipe_stage_cell
//   One pipeline stage: a WIDTH-bit data register plus its valid bit.
//   Priority on each rising edge: clr > flush > stall (hold) > load.
// Ports
//   clk      in   rising-edge clock
//   clr      in   synchronous reset, active-high (data <= RESET_VAL, valid <= 0)
//   flush    in   bubble insert (data <= BUBBLE_VAL, valid <= 0)
//   stall    in   hold current contents
//   data_i   in   WIDTH  data to load
//   valid_i  in   valid tag of data_i
//   data_o   out  WIDTH  registered data
//   valid_o  out  registered valid bit
// ---------------------------------------------------------------------------
module pipe_stage_cell
  import cpu_pipe_pkg::*;
#(
  parameter int unsigned      WIDTH      = 32,
  parameter logic [WIDTH-1:0] RESET_VAL  = '0,
  parameter logic [WIDTH-1:0] BUBBLE_VAL = '0
) (
  input  logic             clk,
  input  logic             clr,
  input  logic             flush,
  input  logic             stall,
  input  logic [WIDTH-1:0] data_i,
  input  logic             valid_i,
  output logic [WIDTH-1:0] data_o,
  output logic             valid_o
);

  logic [WIDTH-1:0] data_q,  data_d;
  logic             valid_q, valid_d;

  always_comb begin
    // NOTE: every comb output gets a default before the case, so no path
    // leaves it unassigned and no latch is inferred.
    data_d  = data_q;
    valid_d = valid_q;
    unique case (decode_op(clr, flush, stall))
      OP_CLR: begin
        data_d  = RESET_VAL;
        valid_d = 1'b0;
      end
      OP_FLUSH: begin
        data_d  = BUBBLE_VAL;
        valid_d = 1'b0;
      end
      OP_HOLD: ;
      OP_LOAD: begin
        // Data is captured whether or not it is valid; valid only tags it.
        data_d  = data_i;
        valid_d = valid_i;
      end
    endcase
  end

  // NOTE: state registers use non-blocking assignment so all stages sample
  // their neighbours' old values on the same edge and the chain shifts.
  always_ff @(posedge clk) begin
    data_q  <= data_d;
    valid_q <= valid_d;
  end

  assign data_o  = data_q;
  assign valid_o = valid_q;

endmodule

// File: rtl/pipe_stage_reg.sv
// ---------------------------------------------------------------------------
// pipe_stage_reg
//   DEPTH-deep chain of WIDTH-bit pipeline registers with per-stage valid
//   bits, shared stall (hold) and shared flush (bubble insert). Used between
//   CPU pipeline stages and as the PC register; the hazard unit drives
//   stall/flush. Latency is DEPTH cycles plus one per stall cycle.
// Ports
//   clk        in   rising-edge clock
//   clr        in   synchronous reset, active-high
//   d          in   WIDTH  stage-0 input data
//   in_valid   in   d carries a real instruction/value
//   stall      in   hold all stages this cycle
//   flush      in   replace all stages with bubbles this cycle
//   q          out  WIDTH  data of last stage
//   out_valid  out  valid bit of last stage
//   busy       out  OR of all stage valid bits (combinational from flops)
// Optional (macro PIPE_STAGE_PERF_CNT_EN defined)
//   stall_cnt  out  CNT_W  edges with stall && !flush && !clr, saturating
//   flush_cnt  out  CNT_W  edges with flush && !clr, saturating
// ---------------------------------------------------------------------------
module pipe_stage_reg
  import cpu_pipe_pkg::*;
#(
  parameter int unsigned      WIDTH      = 32,
  parameter int unsigned      DEPTH      = 1,
  parameter logic [WIDTH-1:0] RESET_VAL  = '0,
  parameter logic [WIDTH-1:0] BUBBLE_VAL = WIDTH'(NOP_INSTR)
) (
  input  logic             clk,
  input  logic             clr,
  input  logic [WIDTH-1:0] d,
  input  logic             in_valid,
  input  logic             stall,
  input  logic             flush,
  output logic [WIDTH-1:0] q,
  output logic             out_valid,
  output logic             busy
`ifdef PIPE_STAGE_PERF_CNT_EN
  ,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
`endif
);

  logic [WIDTH-1:0] stage_data [DEPTH];
  logic [DEPTH-1:0] stage_valid;

  for (genvar i = 0; i < DEPTH; i++) begin : g_stage
    logic [WIDTH-1:0] cell_data;
    logic             cell_valid;

    if (i == 0) begin : g_head
      assign cell_data  = d;
      assign cell_valid = in_valid;
    end else begin : g_body
      assign cell_data  = stage_data[i-1];
      assign cell_valid = stage_valid[i-1];
    end

    pipe_stage_cell #(
      .WIDTH      (WIDTH),
      .RESET_VAL  (RESET_VAL),
      .BUBBLE_VAL (BUBBLE_VAL)
    ) u_cell (
      .clk     (clk),
      .clr     (clr),
      .flush   (flush),
      .stall   (stall),
      .data_i  (cell_data),
      .valid_i (cell_valid),
      .data_o  (stage_data[i]),
      .valid_o (stage_valid[i])
    );
  end

  assign q         = stage_data[DEPTH-1];
  assign out_valid = stage_valid[DEPTH-1];
  assign busy      = |stage_valid;

`ifdef PIPE_STAGE_PERF_CNT_EN
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
  logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;

  // Counters stick at all-ones rather than wrapping.
  always_comb begin
    stall_cnt_d = stall_cnt_q;
    flush_cnt_d = flush_cnt_q;
    if (clr) begin
      stall_cnt_d = '0;
      flush_cnt_d = '0;
    end else begin
      if (stall && !flush && (stall_cnt_q != '1)) stall_cnt_d = stall_cnt_q + 1'b1;
      if (flush && (flush_cnt_q != '1))           flush_cnt_d = flush_cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    stall_cnt_q <= stall_cnt_d;
    flush_cnt_q <= flush_cnt_d;
  end

  assign stall_cnt = stall_cnt_q;
  assign flush_cnt = flush_cnt_q;
`endif

endmodule
